operand_fetch: RTL and testbench

- Fetch/read stage that drives the two-stage execute unit: `fr_pc`, `fr_ins`, `fr_operand_1` and `fr_operand_2`.
- Owns the 16x16 scalar register file and accepts writebacks of the execute stage-2 result.
- Tracks the destinations of the two in-flight execute stages in a scoreboard and inserts bubbles on read-after-write hazards, because the execute pipe has no stall of its own.
- Sits between decode (valid/ready handshake) and execute.

---
 rtl/operand_fetch.sv | 186 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Purpose:
//   Fetch/read stage in front of the two-stage execute unit. It owns the
//   16x16 scalar register file, reads operands for the instruction that
//   decode presents, and tracks the destinations of the two in-flight execute
//   stages in a scoreboard. The execute pipe cannot stall, so a read-after-write
//   hazard is resolved here by issuing a bubble instead of the instruction.
//
// Handshake:
//   Decode presents dec_pc/dec_ins with dec_valid. The instruction is taken on
//   a rising edge where dec_valid && dec_ready. dec_ready is combinational and
//   does not depend on dec_valid. While dec_valid && !dec_ready, decode holds
//   dec_pc/dec_ins stable. An instruction is never dropped except by flush or
//   reset.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   dec_valid/ready      decode handshake
//   dec_pc, dec_ins      presented instruction and its PC
//   flush                redirect: kills the presented and execute-1 instruction
//   wb_en/wb_rt/wb_data  execute stage-2 writeback
//   fr_pc, fr_ins        registered PC/instruction to execute
//   fr_operand_1/2       registered operands to execute
//
// Configuration:
//   OPERAND_FETCH_BYPASS_EN  when defined, a same-cycle writeback is forwarded
//                            to the register read, so an execute-2 match is
//                            not a hazard. Undefined: no forwarding.
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter logic [15:0] BUBBLE_INS = 16'hF000,
  parameter int          NREGS      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [15:0] dec_pc,
  input  logic [15:0] dec_ins,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_rt,
  input  logic [15:0] wb_data,
  output logic [15:0] fr_pc,
  output logic [15:0] fr_ins,
  output logic [15:0] fr_operand_1,
  output logic [15:0] fr_operand_2
);

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } sb_slot_t;

  logic [15:0] rf_q [NREGS];
  sb_slot_t    s1_q, s2_q;
  logic [15:0] fr_pc_q, fr_ins_q, fr_op1_q, fr_op2_q;

  logic [3:0] op, ra, rb, rt, sub;
  assign op  = dec_ins[15:12];
  assign ra  = dec_ins[11:8];
  assign rb  = dec_ins[7:4];
  assign rt  = dec_ins[3:0];
  assign sub = dec_ins[7:4];

  // Two read ports; op1 always comes from port 1 and op2 from port 2, so an
  // unused port simply reads as zero.
  logic       rd1_en, rd2_en;
  logic [3:0] rd1_idx, rd2_idx;
  logic [15:0] rd1_val, rd2_val;
  logic       writer;
  logic       hazard;
  logic       issue;

  always_comb begin
    rd1_en  = 1'b0;
    rd2_en  = 1'b0;
    rd1_idx = 4'd0;
    rd2_idx = 4'd0;
    unique case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'hE: begin
        rd1_en = 1'b1; rd1_idx = ra;
        rd2_en = 1'b1; rd2_idx = rb;
      end
      4'h5: begin
        rd2_en = 1'b1; rd2_idx = rt;
      end
      4'h6: begin
        rd1_en = 1'b1; rd1_idx = ra;
        rd2_en = 1'b1; rd2_idx = rt;
      end
      // Memory ops: op1 carries store data, op2 the address.
      4'h7, 4'hC, 4'hD: begin
        rd1_en = 1'b1; rd1_idx = rt;
        rd2_en = 1'b1; rd2_idx = ra;
      end
      default: begin
      end
    endcase
  end

  // A destination of r0 never creates a scoreboard entry.
  always_comb begin
    writer = 1'b0;
    unique case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE: writer = 1'b1;
      4'h7:    writer = (sub == 4'd0);
      default: writer = 1'b0;
    endcase
    if (rt == 4'd0) writer = 1'b0;
  end

  function automatic logic fwd(input logic [3:0] idx);
`ifdef OPERAND_FETCH_BYPASS_EN
    return wb_en && (wb_rt == idx) && (idx != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] rf_read(input logic [3:0] idx);
    if (idx == 4'd0)   return 16'd0;
    else if (fwd(idx)) return wb_data;
    else               return rf_q[idx];
  endfunction

  function automatic logic src_hz(input logic en, input logic [3:0] idx);
    return en && ((s1_q.valid && s1_q.idx == idx) ||
                  (s2_q.valid && s2_q.idx == idx && !fwd(idx)));
  endfunction

  always_comb begin
    rd1_val = rd1_en ? rf_read(rd1_idx) : 16'd0;
    rd2_val = rd2_en ? rf_read(rd2_idx) : 16'd0;
  end

  assign hazard    = src_hz(rd1_en, rd1_idx) || src_hz(rd2_en, rd2_idx);
  assign dec_ready = !reset && !flush && !hazard;
  assign issue     = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 16'd0;
      s1_q     <= '0;
      s2_q     <= '0;
      fr_pc_q  <= 16'd0;
      fr_ins_q <= BUBBLE_INS;
      fr_op1_q <= 16'd0;
      fr_op2_q <= 16'd0;
    end else begin
      // Writeback commits even during flush: the writer predates the redirect.
      if (wb_en && wb_rt != 4'd0) rf_q[wb_rt] <= wb_data;

      if (issue) begin
        fr_pc_q  <= dec_pc;
        fr_ins_q <= dec_ins;
        fr_op1_q <= rd1_val;
        fr_op2_q <= rd2_val;
      end else begin
        fr_pc_q  <= 16'd0;
        fr_ins_q <= BUBBLE_INS;
        fr_op1_q <= 16'd0;
        fr_op2_q <= 16'd0;
      end

      // Flush kills the execute-1 instruction, so neither slot may keep a
      // hazard alive afterwards.
      if (flush) begin
        s1_q <= '0;
        s2_q <= '0;
      end else begin
        s2_q       <= s1_q;
        s1_q.valid <= issue && writer;
        s1_q.idx   <= (issue && writer) ? rt : 4'd0;
      end
    end
  end

  assign fr_pc        = fr_pc_q;
  assign fr_ins       = fr_ins_q;
  assign fr_operand_1 = fr_op1_q;
  assign fr_operand_2 = fr_op2_q;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed testbench for operand_fetch. Inputs change 1 time unit after a
// rising edge; registered outputs are checked at that point, and dec_ready is
// checked 1 time unit after new inputs settle.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_pc;
  logic [15:0] dec_ins;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_rt;
  logic [15:0] wb_data;
  logic [15:0] fr_pc;
  logic [15:0] fr_ins;
  logic [15:0] fr_operand_1;
  logic [15:0] fr_operand_2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_pc       (dec_pc),
    .dec_ins      (dec_ins),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_rt        (wb_rt),
    .wb_data      (wb_data),
    .fr_pc        (fr_pc),
    .fr_ins       (fr_ins),
    .fr_operand_1 (fr_operand_1),
    .fr_operand_2 (fr_operand_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fr(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                          input logic [15:0] o1, input logic [15:0] o2);
    check({tag, ".pc"},  fr_pc, pc);
    check({tag, ".ins"}, fr_ins, ins);
    check({tag, ".op1"}, fr_operand_1, o1);
    check({tag, ".op2"}, fr_operand_2, o2);
  endtask

  task automatic present(input logic [15:0] pc, input logic [15:0] ins);
    dec_valid = 1'b1;
    dec_pc    = pc;
    dec_ins   = ins;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    dec_pc    = 16'd0;
    dec_ins   = 16'd0;
  endtask

  task automatic wb(input logic [3:0] rt, input logic [15:0] data);
    wb_en   = 1'b1;
    wb_rt   = rt;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_rt = 4'd0; wb_data = 16'd0;
    idle();

    // Reset state
    tick(); tick();
    check_fr("reset", 16'h0000, 16'hF000, 16'h0000, 16'h0000);
    check("reset.ready", {15'd0, dec_ready}, 16'd0);
    reset = 1'b0;

    // add r3,r1,r2 with R1=5, R2=7
    wb(4'd1, 16'd5);
    wb(4'd2, 16'd7);
    present(16'h0010, 16'h0123);
    #1 check("add.ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("add", 16'h0010, 16'h0123, 16'h0005, 16'h0007);

    // movl r4 then dependent add r5,r4,r4
    present(16'h0012, 16'h4004);
    tick();
    check_fr("movl", 16'h0012, 16'h4004, 16'h0000, 16'h0000);
    present(16'h0014, 16'h0445);
    #1 check("raw.s1_ready", {15'd0, dec_ready}, 16'd0);
    tick();
    check_fr("raw.bubble1", 16'h0000, 16'hF000, 16'h0000, 16'h0000);
    wb_en = 1'b1; wb_rt = 4'd4; wb_data = 16'h0012;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 check("raw.s2_ready", {15'd0, dec_ready}, 16'd1);
    tick();
    wb_en = 1'b0;
`else
    #1 check("raw.s2_ready", {15'd0, dec_ready}, 16'd0);
    tick();
    wb_en = 1'b0;
    check_fr("raw.bubble2", 16'h0000, 16'hF000, 16'h0000, 16'h0000);
    #1 check("raw.after_ready", {15'd0, dec_ready}, 16'd1);
    tick();
`endif
    check_fr("raw.issue", 16'h0014, 16'h0445, 16'h0012, 16'h0012);
    idle();

    // Write to r0 is discarded
    wb(4'd0, 16'hBEEF);
    present(16'h0020, 16'h0007);
    #1 check("r0.ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("r0", 16'h0020, 16'h0007, 16'h0000, 16'h0000);

    // Flush while a reader of r6 is stalled on S1; writeback in flush cycle commits
    present(16'h0030, 16'h4006);
    tick();
    present(16'h0032, 16'h0668);
    #1 check("flush.stall_ready", {15'd0, dec_ready}, 16'd0);
    flush = 1'b1;
    wb_en = 1'b1; wb_rt = 4'd11; wb_data = 16'h3333;
    #1 check("flush.ready", {15'd0, dec_ready}, 16'd0);
    tick();
    flush = 1'b0; wb_en = 1'b0;
    check_fr("flush.bubble", 16'h0000, 16'hF000, 16'h0000, 16'h0000);
    present(16'h0040, 16'h0668);
    #1 check("flush.after_ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("flush.reader", 16'h0040, 16'h0668, 16'h0000, 16'h0000);
    present(16'h0042, 16'h0B0C);
    tick();
    check_fr("flush.wb_commit", 16'h0042, 16'h0B0C, 16'h3333, 16'h0000);
    idle();

    // Store: op1 = R[rt] data, op2 = R[ra] address
    wb(4'd10, 16'h0100);
    wb(4'd6, 16'h00AA);
    present(16'h0050, 16'h7A16);
    #1 check("st.ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("st", 16'h0050, 16'h7A16, 16'h00AA, 16'h0100);
    dec_valid = 1'b0;
    tick();
    check_fr("st.novalid", 16'h0000, 16'hF000, 16'h0000, 16'h0000);

    // Reset mid-stall
    present(16'h0060, 16'h4009);
    tick();
    present(16'h0062, 16'h0990);
    #1 check("rst.stall_ready", {15'd0, dec_ready}, 16'd0);
    reset = 1'b1;
    #1 check("rst.ready", {15'd0, dec_ready}, 16'd0);
    tick();
    reset = 1'b0;
    check_fr("rst.bubble", 16'h0000, 16'hF000, 16'h0000, 16'h0000);
    present(16'h0070, 16'h0990);
    #1 check("rst.fresh_ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("rst.fresh", 16'h0070, 16'h0990, 16'h0000, 16'h0000);
    present(16'h0072, 16'h01A2);
    #1 check("rst.rf_ready", {15'd0, dec_ready}, 16'd1);
    tick();
    check_fr("rst.rf_cleared", 16'h0072, 16'h01A2, 16'h0000, 16'h0000);
    present(16'h0074, 16'h7A16);
    tick();
    check_fr("rst.st_cleared", 16'h0074, 16'h7A16, 16'h0000, 16'h0000);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
